// File: rtl/rr_request_agent.sv
// Requester-side companion to the round-robin arbiter: queues job pulses per channel and
// holds request_o for a fixed tenure once granted. Optional REQ watchdog: RR_AGENT_TIMEOUT_EN.
`timescale 1ns/1ps
module rr_request_agent #(
  parameter int REQUIRE_NUM    = 4,
  parameter int PEND_WIDTH     = 4,
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              sys_clk_i,
  input  logic                              rst_i,
  input  logic [REQUIRE_NUM-1:0]            job_i,
  input  logic [REQUIRE_NUM-1:0]            respond_i,
  output logic [REQUIRE_NUM-1:0]            request_o,
  output logic [REQUIRE_NUM-1:0]            busy_o,
  output logic [REQUIRE_NUM-1:0]            done_o,
  output logic [REQUIRE_NUM-1:0]            overflow_o,
`ifdef RR_AGENT_TIMEOUT_EN
  output logic [REQUIRE_NUM-1:0]            timeout_o,
`endif
  output logic [REQUIRE_NUM*PEND_WIDTH-1:0] pending_cnt_o
);

  localparam int                    HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]         HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX  = '1;
`ifdef RR_AGENT_TIMEOUT_EN
  localparam int                    TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]         WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {IDLE, REQ, HOLD, REL} state_t;

  generate
    for (genvar gi = 0; gi < REQUIRE_NUM; gi++) begin : g_chan
      state_t                state_q, state_d;
      logic [PEND_WIDTH-1:0] pend_q, pend_d;
      logic [HW-1:0]         hold_q, hold_d;
      logic                  done_q, done_d;
      logic                  ovf_q, ovf_d;
      logic                  grant;
      logic                  inc;
`ifdef RR_AGENT_TIMEOUT_EN
      logic [TW-1:0]         wait_q, wait_d;
      logic                  to_q, to_d;
`endif

      always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
          state_q <= IDLE;
          pend_q  <= '0;
          hold_q  <= '0;
          done_q  <= 1'b0;
          ovf_q   <= 1'b0;
`ifdef RR_AGENT_TIMEOUT_EN
          wait_q  <= '0;
          to_q    <= 1'b0;
`endif
        end else begin
          state_q <= state_d;
          pend_q  <= pend_d;
          hold_q  <= hold_d;
          done_q  <= done_d;
          ovf_q   <= ovf_d;
`ifdef RR_AGENT_TIMEOUT_EN
          wait_q  <= wait_d;
          to_q    <= to_d;
`endif
        end
      end

      always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        ovf_d   = 1'b0;
`ifdef RR_AGENT_TIMEOUT_EN
        wait_d  = '0;
        to_d    = 1'b0;
`endif
        grant = (state_q == REQ) && respond_i[gi];
        inc   = job_i[gi];

        // A job arriving together with a grant cancels out, so saturation only bites alone.
        if (inc && !grant) begin
          if (pend_q == PEND_MAX) ovf_d = 1'b1;
          else                    pend_d = pend_q + 1'b1;
        end else if (!inc && grant) begin
          pend_d = pend_q - 1'b1;
        end

        case (state_q)
          IDLE: if (pend_q != '0) state_d = REQ;
          REQ: begin
            if (grant) begin
              state_d = HOLD;
              hold_d  = HOLD_LOAD;
            end
`ifdef RR_AGENT_TIMEOUT_EN
            else if (wait_q == WAIT_LAST) begin
              state_d = REL;
              to_d    = 1'b1;
            end else begin
              wait_d = wait_q + 1'b1;
            end
`endif
          end
          HOLD: begin
            if (hold_q == '0) begin
              state_d = REL;
              done_d  = 1'b1;
            end else begin
              hold_d = hold_q - 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end

      assign request_o[gi]                             = (state_q == REQ) || (state_q == HOLD);
      assign busy_o[gi]                                = (state_q == HOLD);
      assign done_o[gi]                                = done_q;
      assign overflow_o[gi]                            = ovf_q;
      assign pending_cnt_o[gi*PEND_WIDTH +: PEND_WIDTH] = pend_q;
`ifdef RR_AGENT_TIMEOUT_EN
      assign timeout_o[gi]                             = to_q;
`endif
    end
  endgenerate

endmodule
